// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: opcode constants, FSM state
// encoding and default instruction field widths.
package fetch_sequencer_pkg;

    localparam int unsigned DEF_PC_W  = 8;
    localparam int unsigned DEF_OP_W  = 6;
    localparam int unsigned DEF_IMM_W = 8;
    localparam int unsigned DEF_IW    = DEF_OP_W + DEF_IMM_W;

    // Opcodes as seen by the decoder
    localparam logic [DEF_OP_W-1:0] OP_NOOP  = 6'b000001;
    localparam logic [DEF_OP_W-1:0] OP_LDP1  = 6'b000010;
    localparam logic [DEF_OP_W-1:0] OP_JUMPX = 6'b001000;
    localparam logic [DEF_OP_W-1:0] OP_STOP  = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } fsm_state_e;

    // States in which a program is actively being sequenced
    function automatic logic is_busy_state(input fsm_state_e s);
        return (s == ST_FETCH) || (s == ST_LOAD) || (s == ST_EXEC);
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_register.sv
// Program counter with clear-to-reset-value, load and increment controls.
// Priority: clear > load > inc > hold. Increment wraps modulo 2^PC_W.
module fetch_sequencer_pc_register #(
    parameter int unsigned         PC_W     = 8,
    parameter logic [PC_W-1:0]     RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] load_value,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_q;

    // Next-PC select: clear, jump load, increment or hold
    always_comb begin
        pc_d = pc_q;
        if (clear) begin
            pc_d = RESET_PC;
        end else if (load) begin
            pc_d = load_value;
        end else if (inc) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // PC state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns PC and IR, issues instruction memory reads and
// sequences FETCH -> LOAD -> EXEC for each instruction until STOP.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W     = DEF_PC_W,
    parameter int unsigned     OP_W     = DEF_OP_W,
    parameter int unsigned     IMM_W    = DEF_IMM_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [PC_W-1:0]       imem_addr,
    output logic                  imem_rd_en,
    input  logic [OP_W+IMM_W-1:0] imem_rdata,
    output logic [OP_W-1:0]       opcode,
    output logic [IMM_W-1:0]      imm_data,
    output logic                  exec_valid,
    input  logic                  pc_en,
    input  logic                  stop_flag,
    input  logic                  pc_load,
    input  logic [PC_W-1:0]       pc_load_value,
    output logic [PC_W-1:0]       pc,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned IW = OP_W + IMM_W;
    localparam logic [IW-1:0] IR_RESET = {OP_W'(OP_NOOP), {IMM_W{1'b0}}};

    fsm_state_e    state_d, state_q;
    logic [IW-1:0] ir_d, ir_q;
    logic          rd_en_d, rd_en_q;
    logic          exec_valid_d, exec_valid_q;
    logic          busy_d, busy_q;
    logic          done_d, done_q;

    logic          pc_clear;
    logic          pc_load_sel;
    logic          pc_inc;
    logic [PC_W-1:0] pc_cur;

    fetch_sequencer_pc_register #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pc_clear),
        .load       (pc_load_sel),
        .inc        (pc_inc),
        .load_value (pc_load_value),
        .pc         (pc_cur)
    );

    // Next-state, IR capture and PC control; outputs are decoded from the
    // next state so they come straight off flops in the matching state.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        pc_clear    = 1'b0;
        pc_load_sel = 1'b0;
        pc_inc      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_clear = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                ir_d    = imem_rdata;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (stop_flag) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    if (pc_load) begin
                        pc_load_sel = 1'b1;
                    end else if (pc_en) begin
                        pc_inc = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_en_d      = (state_d == ST_FETCH);
        exec_valid_d = (state_d == ST_EXEC);
        busy_d       = is_busy_state(state_d);
        done_d       = (state_d == ST_HALT) && (state_q != ST_HALT);
    end

    // FSM state, IR and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ir_q         <= IR_RESET;
            rd_en_q      <= 1'b0;
            exec_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            rd_en_q      <= rd_en_d;
            exec_valid_q <= exec_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign imem_addr  = pc_cur;
    assign imem_rd_en = rd_en_q;
    assign opcode     = ir_q[IW-1:IMM_W];
    assign imm_data   = ir_q[IMM_W-1:0];
    assign exec_valid = exec_valid_q;
    assign pc         = pc_cur;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: the bench models instruction memory
// and plays the decoder by driving pc_en/stop_flag/pc_load in EXEC.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  imem_addr;
    logic        imem_rd_en;
    logic [13:0] imem_rdata;
    logic [5:0]  opcode;
    logic [7:0]  imm_data;
    logic        exec_valid;
    logic        pc_en;
    logic        stop_flag;
    logic        pc_load;
    logic [7:0]  pc_load_value;
    logic [7:0]  pc;
    logic        busy;
    logic        done;

    logic [13:0] imem [256];

    int n_cmp;
    int n_err;

    fetch_sequencer #(
        .PC_W     (8),
        .OP_W     (6),
        .IMM_W    (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_addr     (imem_addr),
        .imem_rd_en    (imem_rd_en),
        .imem_rdata    (imem_rdata),
        .opcode        (opcode),
        .imm_data      (imm_data),
        .exec_valid    (exec_valid),
        .pc_en         (pc_en),
        .stop_flag     (stop_flag),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .pc            (pc),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= imem[imem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dec(input logic pe, input logic sf, input logic pl, input logic [7:0] plv);
        pc_en         = pe;
        stop_flag     = sf;
        pc_load       = pl;
        pc_load_value = plv;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) imem[i] = {OP_NOOP, 8'h00};
        imem[0]     = {OP_LDP1, 8'h05};
        imem[1]     = {OP_STOP, 8'h00};
        imem[8'hFF] = {OP_NOOP, 8'hAA};
        imem_rdata  = '0;
        rst_n = 1'b0;
        start = 1'b0;
        dec(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_exec_valid", exec_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", imem_rd_en, 0);
        chk("rst_opcode", opcode, OP_NOOP);
        chk("rst_imm", imm_data, 0);
        chk("rst_pc", pc, 0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // Program: LDP1 5 ; STOP
        start = 1'b1;
        step();
        chk("f0_rd_en", imem_rd_en, 1);
        chk("f0_addr", imem_addr, 8'h00);
        chk("f0_busy", busy, 1);
        chk("f0_exec", exec_valid, 0);
        step();
        chk("l0_rd_en", imem_rd_en, 0);
        chk("l0_exec", exec_valid, 0);
        step();
        chk("e0_exec", exec_valid, 1);
        chk("e0_opcode", opcode, OP_LDP1);
        chk("e0_imm", imm_data, 8'h05);
        dec(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        chk("f1_addr", imem_addr, 8'h01);
        chk("f1_exec", exec_valid, 0);
        dec(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        step();
        chk("e1_opcode", opcode, OP_STOP);
        chk("e1_exec", exec_valid, 1);
        // STOP outranks a simultaneous jump
        dec(1'b0, 1'b1, 1'b1, 8'h33);
        step();
        chk("halt_done", done, 1);
        chk("halt_busy", busy, 0);
        chk("halt_exec", exec_valid, 0);
        chk("halt_pc", pc, 8'h01);
        dec(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        chk("halt_done_pulse", done, 0);
        chk("halt_ir_hold", opcode, OP_STOP);
        step();
        chk("halt_stay_rd_en", imem_rd_en, 0);
        chk("halt_stay_busy", busy, 0);

        // Restart via start low then high
        start = 1'b0;
        step();
        chk("idle2_busy", busy, 0);
        start = 1'b1;
        step();
        chk("rs_rd_en", imem_rd_en, 1);
        chk("rs_addr", imem_addr, 8'h00);
        step();
        step();
        chk("rs_e_opcode", opcode, OP_LDP1);
        // Load beats increment
        dec(1'b1, 1'b0, 1'b1, 8'h20);
        step();
        chk("jmp_addr", imem_addr, 8'h20);
        chk("jmp_rd_en", imem_rd_en, 1);
        dec(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        step();
        chk("n20_exec", exec_valid, 1);
        chk("n20_opcode", opcode, OP_NOOP);
        // Stall: no pc_en, no stop
        step();
        chk("stall_addr", imem_addr, 8'h20);
        // Decoder inputs outside EXEC must be ignored
        dec(1'b1, 1'b1, 1'b1, 8'h77);
        step();
        chk("ign_pc_load", pc, 8'h20);
        step();
        chk("stall_exec", exec_valid, 1);
        chk("stall_opcode", opcode, OP_NOOP);
        chk("stall_pc", pc, 8'h20);
        dec(1'b0, 1'b0, 1'b1, 8'hFF);
        step();
        chk("ff_addr", imem_addr, 8'hFF);
        dec(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        step();
        chk("ff_imm", imm_data, 8'hAA);
        dec(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        chk("wrap_addr", imem_addr, 8'h00);
        chk("wrap_rd_en", imem_rd_en, 1);
        dec(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        step();
        chk("w_opcode", opcode, OP_LDP1);
        dec(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        dec(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        // Now in LOAD with IR = LDP1; asynchronous reset mid-instruction
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_opcode", opcode, OP_LDP1);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("arst_exec", exec_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_opcode", opcode, OP_NOOP);
        chk("arst_imm", imm_data, 0);
        chk("arst_pc", pc, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);
        start = 1'b1;
        step();
        chk("post_rst_rd_en", imem_rd_en, 1);
        chk("post_rst_addr", imem_addr, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream stage of the instruction decoder in the downsampling processor.
- Owns the program counter (PC) and instruction register (IR), and issues synchronous reads to instruction memory.
- Presents one opcode plus immediate per instruction to the decoder.
- Consumes the decoder's pc_en / stop_flag and the datapath's jump load to sequence execution between start and STOP.

Parameters:
PC_W, 8, program counter / instruction memory address width
OP_W, 6, opcode field width
IMM_W, 8, immediate field width; instruction word width = OP_W+IMM_W
RESET_PC, 0, PC value loaded at reset and on each start

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level; begin program execution from RESET_PC
imem_addr  out  PC_W  instruction memory read address
imem_rd_en  out  1  instruction memory read strobe
imem_rdata  in  OP_W+IMM_W  read data, valid one cycle after imem_rd_en
opcode  out  OP_W  IR[OP_W+IMM_W-1:IMM_W] to decoder
imm_data  out  IMM_W  IR[IMM_W-1:0] to b_bus immediate source
exec_valid  out  1  high only in EXEC; datapath qualifies every register/memory write with it
pc_en  in  1  decoder: advance PC after this instruction
stop_flag  in  1  decoder: STOP executed
pc_load  in  1  jump taken (PC selected on c_bus)
pc_load_value  in  PC_W  jump target from c_bus
pc  out  PC_W  current PC, for debug
busy  out  1  high in FETCH, LOAD, EXEC
done  out  1  one-cycle pulse on entry to HALT

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE, PC=RESET_PC
  - IR={NOOP 6'b000001, imm 0}
  - imem_rd_en=0, exec_valid=0, busy=0, done=0
- FSM: IDLE, FETCH, LOAD, EXEC, HALT. Each instruction takes 3 cycles (FETCH→LOAD→EXEC).
- IDLE:
  - outputs idle.
  - start=1 → PC<=RESET_PC, go to FETCH.
- FETCH:
  - imem_rd_en=1, imem_addr=PC.
  - Always → LOAD.
- LOAD:
  - IR<=imem_rdata (registered).
  - Always → EXEC.
- EXEC:
  - exec_valid=1; opcode/imm_data are stable all cycle. Evaluated at the clock edge, priority order:
  - 1. stop_flag=1 → PC unchanged, go to HALT, done pulses next cycle.
  - 2. pc_load=1 → PC<=pc_load_value, go to FETCH. pc_load wins over pc_en.
  - 3. pc_en=1 → PC<=PC+1 modulo 2^PC_W (PC=2^PC_W-1 wraps to 0), go to FETCH.
  - 4. pc_en=0 (no stop) → PC held, go to FETCH; the same instruction re-executes (stall).
- HALT:
  - busy=0; IR holds the last instruction; exec_valid=0.
  - start=0 → IDLE. start held high stays in HALT, so no auto-restart.
- start is ignored outside IDLE/HALT. Deasserting start mid-program does not abort it.
- Decoder inputs (pc_en, stop_flag, pc_load) are sampled only in EXEC and ignored in other states.
- imem_addr is driven with PC in all states; only imem_rd_en qualifies it.
- opcode is sourced straight from IR, with no combinational path from imem_rdata.
- rst_n asserted mid-instruction → immediate return to reset values; no partial write is possible, because exec_valid drops asynchronously.

Decomposition:
- Shared package holds:
  - opcode constants (NOOP, STOP, JUMPX, … as used by the decoder)
  - FSM state encoding (3-bit: IDLE=0, FETCH=1, LOAD=2, EXEC=3, HALT=4)
  - default instruction width constants
- One natural sub-module: pc_register. It contains the PC, the load/increment/hold mux and wrap, and takes load, inc, and clear-to-RESET_PC controls.
- The FSM and IR stay in fetch_sequencer.

Test Plan:
- Reset then start=1, imem[0]={LDP1,8'h05}, imem[1]={STOP,0} → opcode=6'b000010, imm_data=8'h05 with exec_valid=1 in cycle 4 after start. STOP in EXEC at cycle 7. done pulses cycle 8. pc=1 in HALT.
- Program of NOOPs with PC_W=8, forced PC=8'hFF, pc_en=1 → next imem_addr=8'h00; no X, no hang.
- EXEC with pc_en=1, pc_load=1, pc_load_value=8'h20 → next FETCH imem_addr=8'h20 (load beats increment).
- EXEC with pc_en=0, stop_flag=0 → PC unchanged, same opcode presented again 3 cycles later with exec_valid=1.
- stop_flag=1 with pc_load=1 → HALT, PC not loaded. start held high stays in HALT. start 0→1 restarts at imem_addr=RESET_PC.
- rst_n pulsed low during LOAD → exec_valid=0, busy=0, opcode=6'b000001 immediately (before next clk edge). PC=RESET_PC.
